// File: rtl/alu_seq_pkg.sv
// Shared opcode, decoder-control and FSM encodings for the ALU operation sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_MOV     = 4'd0;
    localparam logic [3:0] OP_ADD     = 4'd1;
    localparam logic [3:0] OP_SUB     = 4'd2;
    localparam logic [3:0] OP_AND     = 4'd3;
    localparam logic [3:0] OP_OR      = 4'd4;
    localparam logic [3:0] OP_XOR     = 4'd5;
    localparam logic [3:0] OP_NOT     = 4'd6;
    localparam logic [3:0] OP_INC     = 4'd7;
    localparam logic [3:0] OP_DEC     = 4'd8;
    localparam logic [3:0] OP_SLA     = 4'd9;
    localparam logic [3:0] OP_SLL     = 4'd10;
    localparam logic [3:0] OP_ROL     = 4'd11;
    localparam logic [3:0] OP_SRA     = 4'd12;
    localparam logic [3:0] OP_SRL     = 4'd13;
    localparam logic [3:0] OP_ROR     = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    // Literals are alu_ctrl[5:0], i.e. Ctrl5 on the left; the decoder table lists Ctrl0 first.
    localparam logic [5:0] CTRL_MOV = 6'b000000;
    localparam logic [5:0] CTRL_ADD = 6'b010010;
    localparam logic [5:0] CTRL_SUB = 6'b100010;
    localparam logic [5:0] CTRL_AND = 6'b011000;
    localparam logic [5:0] CTRL_OR  = 6'b010100;
    localparam logic [5:0] CTRL_XOR = 6'b011100;
    localparam logic [5:0] CTRL_NOT = 6'b001100;
    localparam logic [5:0] CTRL_INC = 6'b110110;
    localparam logic [5:0] CTRL_DEC = 6'b000110;
    localparam logic [5:0] CTRL_SLA = 6'b001001;
    localparam logic [5:0] CTRL_SLL = 6'b000001;
    localparam logic [5:0] CTRL_ROL = 6'b010001;
    localparam logic [5:0] CTRL_SRA = 6'b001101;
    localparam logic [5:0] CTRL_SRL = 6'b000101;
    localparam logic [5:0] CTRL_ROR = 6'b010101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and completion handshakes between an operation requester and the sequencer.
interface alu_op_sequencer_if #(parameter int CNT_W = 4);

    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [CNT_W-1:0] op_count;
    logic             done_valid;
    logic             done_ready;
    logic             done_err;

    modport master (
        output op_valid, op_code, op_count, done_ready,
        input  op_ready, done_valid, done_err
    );

    modport slave (
        input  op_valid, op_code, op_count, done_ready,
        output op_ready, done_valid, done_err
    );

endinterface

// File: rtl/alu_op_sequencer_lut.sv
// Combinational opcode decode: decoder control word plus shift/illegal classification.
module alu_ctrl_lut
    import alu_seq_pkg::*;
(
    input  logic [3:0] op_code,
    output logic       is_shift,
    output logic       illegal,
    output logic [5:0] ctrl
);

    always_comb begin
        is_shift = 1'b0;
        illegal  = 1'b0;
        ctrl     = CTRL_MOV;
        case (op_code)
            OP_MOV: ctrl = CTRL_MOV;
            OP_ADD: ctrl = CTRL_ADD;
            OP_SUB: ctrl = CTRL_SUB;
            OP_AND: ctrl = CTRL_AND;
            OP_OR:  ctrl = CTRL_OR;
            OP_XOR: ctrl = CTRL_XOR;
            OP_NOT: ctrl = CTRL_NOT;
            OP_INC: ctrl = CTRL_INC;
            OP_DEC: ctrl = CTRL_DEC;
            OP_SLA: begin ctrl = CTRL_SLA; is_shift = 1'b1; end
            OP_SLL: begin ctrl = CTRL_SLL; is_shift = 1'b1; end
            OP_ROL: begin ctrl = CTRL_ROL; is_shift = 1'b1; end
            OP_SRA: begin ctrl = CTRL_SRA; is_shift = 1'b1; end
            OP_SRL: begin ctrl = CTRL_SRL; is_shift = 1'b1; end
            OP_ROR: begin ctrl = CTRL_ROR; is_shift = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front-end controller: accepts one operation per handshake, drives the decoder
// control lines, sequences multi-pass shifts and owns the carry flag.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_sequencer_if.slave op,
    output logic [5:0]       alu_ctrl,
    output logic             alu_c_flag,
    input  logic             alu_c_out,
    output logic             a_sel,
    output logic             acc_we,
    output logic             flag_we
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             c_flag_q;
    logic             op_ready_q, done_valid_q, done_err_q;
    logic [5:0]       ctrl_d;
    logic             a_sel_d, we_d, err_d;
    logic [3:0]       lut_op;
    logic [5:0]       lut_ctrl;
    logic             lut_shift, lut_illegal;
    logic             accept;

    assign accept = op.op_valid & op_ready_q;
    assign lut_op = (state_q == ST_IDLE) ? op.op_code : op_q;

    alu_ctrl_lut u_lut (
        .op_code  (lut_op),
        .is_shift (lut_shift),
        .illegal  (lut_illegal),
        .ctrl     (lut_ctrl)
    );

    // Next-cycle outputs are decoded here and registered, so every pass sees stable controls.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ctrl_d      = CTRL_MOV;
        a_sel_d     = 1'b0;
        we_d        = 1'b0;
        err_d       = done_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (lut_illegal) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (lut_shift) begin
                        if (op.op_count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d     = ST_SHIFT;
                            remaining_d = op.op_count;
                            ctrl_d      = lut_ctrl;
                            we_d        = 1'b1;
                        end
                    end else begin
                        state_d = ST_EXEC;
                        ctrl_d  = lut_ctrl;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_SHIFT: begin
                remaining_d = remaining_q - ONE;
                if (remaining_q == ONE) begin
                    state_d = ST_DONE;
                end else begin
                    ctrl_d  = lut_ctrl;
                    we_d    = 1'b1;
                    a_sel_d = 1'b1;
                end
            end
            default: begin
                if (done_valid_q && op.done_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_MOV;
            remaining_q  <= '0;
            c_flag_q     <= 1'b0;
            op_ready_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            alu_ctrl     <= CTRL_MOV;
            a_sel        <= 1'b0;
            acc_we       <= 1'b0;
            flag_we      <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            op_ready_q   <= (state_d == ST_IDLE);
            done_valid_q <= (state_d == ST_DONE);
            done_err_q   <= err_d;
            alu_ctrl     <= ctrl_d;
            a_sel        <= a_sel_d;
            acc_we       <= we_d;
            flag_we      <= we_d;
            if (accept) op_q <= op.op_code;
            if (flag_we) c_flag_q <= alu_c_out;
        end
    end

    assign op.op_ready   = op_ready_q;
    assign op.done_valid = done_valid_q;
    assign op.done_err   = done_err_q;
    assign alu_c_flag    = c_flag_q;

endmodule
